// File: rtl/sig_mem_pkg.sv
// Shared constants, channel/state encodings and round-robin helper for the
// VGA signal-memory writer.
package sig_mem_pkg;

    localparam logic [11:0] ECG_BASE = 12'h559;
    localparam logic [11:0] EMG_BASE = 12'h6AD;
    localparam logic [11:0] BPM_ADDR = 12'h6A8;

    localparam int                PTR_W     = 9;
    localparam logic [PTR_W-1:0]  TRACE_LEN = 9'd335;
    localparam logic [9:0]        BPM_MAX   = 10'd999;
    localparam int                DEC_LOG2  = 2;

    // ECG_BASE..EMG_BASE+TRACE_LEN-1 inclusive
    localparam logic [9:0]        CLEAR_LEN = 10'd675;

    typedef enum logic [1:0] {
        CH_ECG = 2'd0,
        CH_EMG = 2'd1,
        CH_BPM = 2'd2
    } ch_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic ch_e rr_next(input ch_e c);
        case (c)
            CH_ECG:  return CH_EMG;
            CH_EMG:  return CH_BPM;
            default: return CH_ECG;
        endcase
    endfunction

endpackage

// File: rtl/sig_chan_ring.sv
// One trace channel: holding register, ready/pending handshake and circular
// sweep pointer. SIG_DECIMATE_EN adds a 2^DEC_LOG2 averaging decimator.
module sig_chan_ring
    import sig_mem_pkg::*;
#(
    parameter logic [11:0] BASE = ECG_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        valid,
    input  logic [11:0] data,
    input  logic        grant,
    output logic        ready,
    output logic        pending,
    output logic [11:0] addr,
    output logic [31:0] wdata
);

    logic [11:0]      hold;
    logic [PTR_W-1:0] ptr;
    logic             accept;
    logic             take;
    logic [11:0]      sample;

    assign ready  = run && !pending;
    assign accept = valid && ready;
    assign addr   = BASE + {{(12-PTR_W){1'b0}}, ptr};
    assign wdata  = {20'b0, hold};

`ifdef SIG_DECIMATE_EN
    logic [12+DEC_LOG2-1:0] acc;
    logic [12+DEC_LOG2-1:0] sum;
    logic [DEC_LOG2-1:0]    cnt;

    assign sum    = acc + {{DEC_LOG2{1'b0}}, data};
    assign take   = accept && (&cnt);
    assign sample = sum[12+DEC_LOG2-1:DEC_LOG2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= (&cnt) ? '0 : sum;
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign take   = accept;
    assign sample = data;
`endif

    // take and grant are exclusive: grant needs pending, take needs !pending
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            hold    <= '0;
            ptr     <= '0;
        end else begin
            if (take) begin
                pending <= 1'b1;
                hold    <= sample;
            end else if (grant) begin
                pending <= 1'b0;
            end
            if (grant)
                ptr <= (ptr == TRACE_LEN - 1'b1) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sig_mem_writer.sv
// Signal-memory producer: zero-fills the trace/BPM window after reset, then
// round-robins ECG/EMG/BPM writes. Optional decimation via SIG_DECIMATE_EN.
module sig_mem_writer
    import sig_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ecg_valid,
    input  logic [11:0] ecg_data,
    output logic        ecg_ready,
    input  logic        emg_valid,
    input  logic [11:0] emg_data,
    output logic        emg_ready,
    input  logic        bpm_valid,
    input  logic [31:0] bpm_data,
    output logic        mem_wEn,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        clearing
);

    state_e      state, state_nx;
    logic [9:0]  clr_cnt;
    ch_e         rr_last;
    logic        run;
    logic        bpm_pend;
    logic [9:0]  bpm_val;
    logic [9:0]  bpm_sat;

    logic        ecg_pend, emg_pend;
    logic [11:0] ecg_addr, emg_addr;
    logic [31:0] ecg_wdata, emg_wdata;

    logic [2:0]  req;
    ch_e         c1, c2, c3, gnt_ch;
    logic        gnt_any;
    logic        ecg_gnt, emg_gnt, bpm_gnt;
    logic [11:0] sel_addr;
    logic [31:0] sel_data;

    assign run      = (state == ST_RUN);
    assign clearing = !run;

    sig_chan_ring #(.BASE(ECG_BASE)) u_ecg (
        .clock(clock), .reset(reset), .run(run),
        .valid(ecg_valid), .data(ecg_data), .grant(ecg_gnt),
        .ready(ecg_ready), .pending(ecg_pend), .addr(ecg_addr), .wdata(ecg_wdata)
    );

    sig_chan_ring #(.BASE(EMG_BASE)) u_emg (
        .clock(clock), .reset(reset), .run(run),
        .valid(emg_valid), .data(emg_data), .grant(emg_gnt),
        .ready(emg_ready), .pending(emg_pend), .addr(emg_addr), .wdata(emg_wdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_CLEAR;
        else        state <= state_nx;
    end

    // Last clear word goes out on the edge that enters RUN
    always_comb begin
        state_nx = state;
        if (state == ST_CLEAR && clr_cnt == CLEAR_LEN - 1'b1)
            state_nx = ST_RUN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 clr_cnt <= '0;
        else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    assign bpm_sat = (bpm_data > {22'b0, BPM_MAX}) ? BPM_MAX : bpm_data[9:0];

    // A fresh value overrides the grant so the latest BPM is never dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bpm_pend <= 1'b0;
            bpm_val  <= '0;
        end else if (bpm_valid) begin
            bpm_pend <= 1'b1;
            bpm_val  <= bpm_sat;
        end else if (bpm_gnt) begin
            bpm_pend <= 1'b0;
        end
    end

    always_comb begin
        req     = {bpm_pend, emg_pend, ecg_pend};
        c1      = rr_next(rr_last);
        c2      = rr_next(c1);
        c3      = rr_next(c2);
        gnt_any = 1'b0;
        gnt_ch  = CH_ECG;
        if (run) begin
            if (req[c1]) begin
                gnt_any = 1'b1; gnt_ch = c1;
            end else if (req[c2]) begin
                gnt_any = 1'b1; gnt_ch = c2;
            end else if (req[c3]) begin
                gnt_any = 1'b1; gnt_ch = c3;
            end
        end
    end

    assign ecg_gnt = gnt_any && (gnt_ch == CH_ECG);
    assign emg_gnt = gnt_any && (gnt_ch == CH_EMG);
    assign bpm_gnt = gnt_any && (gnt_ch == CH_BPM);

    always_comb begin
        sel_addr = ecg_addr;
        sel_data = ecg_wdata;
        case (gnt_ch)
            CH_EMG: begin sel_addr = emg_addr; sel_data = emg_wdata;         end
            CH_BPM: begin sel_addr = BPM_ADDR; sel_data = {22'b0, bpm_val}; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_last <= CH_ECG;
        else if (gnt_any)
            rr_last <= gnt_ch;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_wEn  <= 1'b0;
            mem_addr <= ECG_BASE;
            mem_data <= '0;
        end else if (state == ST_CLEAR) begin
            mem_wEn  <= 1'b1;
            mem_addr <= ECG_BASE + {2'b0, clr_cnt};
            mem_data <= '0;
        end else begin
            mem_wEn <= gnt_any;
            if (gnt_any) begin
                mem_addr <= sel_addr;
                mem_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_sig_mem_writer.sv
// Directed self-checking bench for sig_mem_writer (clear sweep, ring wrap,
// arbitration order, BPM saturation, async reset, optional decimation).
module tb_sig_mem_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ecg_valid, emg_valid, bpm_valid;
    logic [11:0] ecg_data, emg_data;
    logic [31:0] bpm_data;
    logic        ecg_ready, emg_ready;
    logic        mem_wEn;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        clearing;

    int tests = 0;
    int fails = 0;

`ifdef SIG_DECIMATE_EN
    localparam int REP = 4;
`else
    localparam int REP = 1;
`endif

    sig_mem_writer dut (
        .clock(clock), .reset(reset),
        .ecg_valid(ecg_valid), .ecg_data(ecg_data), .ecg_ready(ecg_ready),
        .emg_valid(emg_valid), .emg_data(emg_data), .emg_ready(emg_ready),
        .bpm_valid(bpm_valid), .bpm_data(bpm_data),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_data(mem_data),
        .clearing(clearing)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_raw(input bit e, input bit m, input bit b,
                            input logic [11:0] ed, input logic [11:0] md, input logic [31:0] bd);
        @(negedge clock);
        ecg_valid = e; ecg_data = ed;
        emg_valid = m; emg_data = md;
        bpm_valid = b; bpm_data = bd;
        @(posedge clock);
        #1;
        ecg_valid = 0; emg_valid = 0; bpm_valid = 0;
    endtask

    // Repeating a constant sample keeps the decimated value equal to it
    task automatic send(input bit e, input bit m, input bit b,
                        input logic [11:0] ed, input logic [11:0] md, input logic [31:0] bd);
        for (int r = 0; r < REP; r++)
            send_raw(e, m, b && (r == REP - 1), ed, md, bd);
    endtask

    task automatic wait_wr(output bit ok, output int lat, output logic [11:0] a, output logic [31:0] d);
        ok = 0; lat = 0; a = '0; d = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (mem_wEn) begin
                ok = 1; lat = c; a = mem_addr; d = mem_data;
                break;
            end
        end
    endtask

    task automatic clear_seq(input string tag);
        int n, bad;
        logic [11:0] exp_a, last_a;
        n = 0; bad = 0; exp_a = 12'h559; last_a = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            if (mem_wEn) begin
                if (mem_addr !== exp_a || mem_data !== 32'd0) bad++;
                last_a = mem_addr;
                exp_a++;
                n++;
            end else if (!clearing) begin
                break;
            end
        end
        check({tag, "_count"}, n, 675);
        check({tag, "_bad"}, bad, 0);
        check({tag, "_last"}, last_a, 12'h7FB);
        check({tag, "_clearing"}, clearing, 0);
        check({tag, "_ecg_rdy"}, ecg_ready, 1);
        check({tag, "_emg_rdy"}, emg_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat, nto, nwr;
        logic [11:0] a, a335, a336;
        logic [31:0] d, d336;

        reset = 0;
        ecg_valid = 0; emg_valid = 0; bpm_valid = 0;
        ecg_data = '0; emg_data = '0; bpm_data = '0;
        repeat (3) @(negedge clock);
        check("rst_wen", mem_wEn, 0);
        check("rst_addr", mem_addr, 12'h559);
        check("rst_data", mem_data, 0);
        check("rst_clearing", clearing, 1);
        check("rst_ecg_rdy", ecg_ready, 0);
        check("rst_emg_rdy", emg_ready, 0);
        reset = 1;

        clear_seq("clr1");

        // single ECG samples
        send(1, 0, 0, 12'hABC, 0, 0);
        wait_wr(ok, lat, a, d);
        check("ecg1_seen", ok, 1);
        check("ecg1_lat", lat, 2);
        check("ecg1_addr", a, 12'h559);
        check("ecg1_data", d, 32'h00000ABC);
        send(1, 0, 0, 12'h123, 0, 0);
        wait_wr(ok, lat, a, d);
        check("ecg2_addr", a, 12'h55A);
        check("ecg2_data", d, 32'h00000123);

        // EMG ring wrap
        nto = 0; a335 = '0; a336 = '0; d336 = '0;
        for (int i = 0; i < 336; i++) begin
            send(0, 1, 0, 0, 12'(i + 1), 0);
            wait_wr(ok, lat, a, d);
            if (!ok) nto++;
            if (i == 334) a335 = a;
            if (i == 335) begin a336 = a; d336 = d; end
        end
        check("wrap_timeouts", nto, 0);
        check("wrap_335_addr", a335, 12'h7FB);
        check("wrap_336_addr", a336, 12'h6AD);
        check("wrap_336_data", d336, 32'd336);

        // all three at once; last served was EMG -> BPM, ECG, EMG
        send(1, 1, 1, 12'h111, 12'h222, 32'd72);
        wait_wr(ok, lat, a, d);
        check("rr0_addr", a, 12'h6A8);
        check("rr0_data", d, 32'd72);
        @(negedge clock);
        check("rr1_wen", mem_wEn, 1);
        check("rr1_addr", mem_addr, 12'h55B);
        check("rr1_data", mem_data, 32'h111);
        @(negedge clock);
        check("rr2_wen", mem_wEn, 1);
        check("rr2_addr", mem_addr, 12'h6AE);
        check("rr2_data", mem_data, 32'h222);
        @(negedge clock);
        check("idle_wen", mem_wEn, 0);

        send(0, 0, 1, 0, 0, 32'd1500);
        wait_wr(ok, lat, a, d);
        check("bpm_sat_addr", a, 12'h6A8);
        check("bpm_sat_data", d, 32'd999);

        // async reset during an ECG write with EMG still pending
        send(1, 1, 0, 12'h5A5, 12'h3C3, 0);
        @(posedge clock);
        #1;
        check("mid_wen", mem_wEn, 1);
        check("mid_addr", mem_addr, 12'h55C);
        #2;
        reset = 0;
        #1;
        check("async_wen", mem_wEn, 0);
        check("async_addr", mem_addr, 12'h559);
        check("async_clearing", clearing, 1);
        check("async_ecg_rdy", ecg_ready, 0);
        @(negedge clock);
        reset = 1;
        clear_seq("clr2");
        send(1, 0, 0, 12'h0F0, 0, 0);
        wait_wr(ok, lat, a, d);
        check("post_rst_addr", a, 12'h559);
        check("post_rst_data", d, 32'h0F0);

`ifdef SIG_DECIMATE_EN
        nwr = 0;
        for (int k = 1; k <= 3; k++) begin
            send_raw(1, 0, 0, 12'(4 * k), 0, 0);
            repeat (3) begin
                @(negedge clock);
                if (mem_wEn) nwr++;
            end
        end
        check("dec_partial_writes", nwr, 0);
        send_raw(1, 0, 0, 12'd16, 0, 0);
        wait_wr(ok, lat, a, d);
        check("dec_addr", a, 12'h55A);
        check("dec_data", d, 32'd10);
`else
        nwr = 0;
        send_raw(1, 0, 0, 12'd4, 0, 0);
        wait_wr(ok, lat, a, d);
        if (ok) nwr++;
        check("nodec_writes", nwr, 1);
        check("nodec_addr", a, 12'h55A);
        check("nodec_data", d, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
